// File: rtl/frame_draw_arbiter_pkg.sv
// Shared frame-manager constants: draw-surface geometry, bus widths, idle source ID.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package frame_draw_arbiter_pkg;

  localparam int DRAW_WIDTH        = 160;
  localparam int DRAW_HEIGHT       = 120;
  localparam int DRAW_WIDTH_ADDRW  = $clog2(DRAW_WIDTH);
  localparam int DRAW_HEIGHT_ADDRW = $clog2(DRAW_HEIGHT);
  localparam int COLOR_DEPTH       = 8;
  localparam int FB_ADDRW          = $clog2(DRAW_WIDTH * DRAW_HEIGHT);

  // One bit wider than the default source count needs, so the all-ones idle
  // ID can never alias a real source (supports up to 7 sources).
  localparam int SOURCE_SEL_ADDRW = 3;
  localparam logic [SOURCE_SEL_ADDRW-1:0] IDLE_SOURCE_ID = '1;

  // Linear framebuffer address of pixel (x, y), unsigned at FB_ADDRW width.
  function automatic logic [FB_ADDRW-1:0] pixel_addr(
    input logic [DRAW_WIDTH_ADDRW-1:0]  x,
    input logic [DRAW_HEIGHT_ADDRW-1:0] y
  );
    return FB_ADDRW'(y) * FB_ADDRW'(DRAW_WIDTH) + FB_ADDRW'(x);
  endfunction

endpackage

// File: rtl/draw_addr_gen.sv
// Beat register: filters a pixel beat and turns (x, y) into a framebuffer write.
// Latency: exactly 1 cycle from beat to fb_we/fb_addr/fb_data.
// Backpressure: none; every accepted beat is written, rejected beats vanish.
module draw_addr_gen
  import frame_draw_arbiter_pkg::*;
(
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         beat_vld,
  input  logic                         beat_transparent,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  beat_x,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] beat_y,
  input  logic [COLOR_DEPTH-1:0]       beat_color,
  output logic                         fb_we,
  output logic [FB_ADDRW-1:0]          fb_addr,
  output logic [COLOR_DEPTH-1:0]       fb_data
);

  localparam logic [DRAW_WIDTH_ADDRW-1:0]  X_LIMIT = DRAW_WIDTH_ADDRW'(DRAW_WIDTH);
  localparam logic [DRAW_HEIGHT_ADDRW-1:0] Y_LIMIT = DRAW_HEIGHT_ADDRW'(DRAW_HEIGHT);

  logic                   we_d, we_q;
  logic [FB_ADDRW-1:0]    addr_d, addr_q;
  logic [COLOR_DEPTH-1:0] data_d, data_q;

  // Accept only opaque, on-screen beats; others are dropped without any signal.
  always_comb begin
    we_d   = beat_vld && !beat_transparent && (beat_x < X_LIMIT) && (beat_y < Y_LIMIT);
    addr_d = pixel_addr(beat_x, beat_y);
    data_d = beat_color;
  end

  // Write-port register; address/data only move on an accepted beat.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= we_d;
      if (we_d) begin
        addr_q <= addr_d;
        data_q <= data_d;
      end
    end
  end

  assign fb_we   = we_q;
  assign fb_addr = addr_q;
  assign fb_data = data_q;

endmodule

// File: rtl/frame_draw_arbiter.sv
// Composes the back framebuffer: optional clear pass, then polls each draw source in turn.
// Latency: framebuffer writes trail the clear counter / bus beat by exactly 1 cycle.
// Backpressure: none on the bus; a silent source is skipped after TIMEOUT_CYCLES of waiting.
module frame_draw_arbiter
  import frame_draw_arbiter_pkg::*;
#(
  parameter int                     SOURCE_COUNT   = 4,
  parameter int                     TIMEOUT_CYCLES = 4096,
  parameter logic [COLOR_DEPTH-1:0] CLEAR_COLOR    = '0
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         frame_start,
  input  logic                         clear_en,
  output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
  output logic                         write_awaited,
  input  logic                         write_active,
  input  logic                         write_transparent,
  input  logic [COLOR_DEPTH-1:0]       write_color_data,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
  output logic                         fb_we,
  output logic [FB_ADDRW-1:0]          fb_addr,
  output logic [COLOR_DEPTH-1:0]       fb_data,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun,
  output logic                         timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0]            TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SOURCE_SEL_ADDRW-1:0] SRC_LAST = SOURCE_SEL_ADDRW'(SOURCE_COUNT - 1);
  localparam logic [DRAW_WIDTH_ADDRW-1:0]  CLR_X_LAST = DRAW_WIDTH_ADDRW'(DRAW_WIDTH - 1);
  localparam logic [DRAW_HEIGHT_ADDRW-1:0] CLR_Y_LAST = DRAW_HEIGHT_ADDRW'(DRAW_HEIGHT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SELECT,
    ST_WAIT,
    ST_STREAM,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t                        state_d, state_q;
  logic [SOURCE_SEL_ADDRW-1:0]   src_d, src_q;
  logic [TMO_W-1:0]              tmo_cnt_d, tmo_cnt_q;
  logic [DRAW_WIDTH_ADDRW-1:0]   clr_x_d, clr_x_q;
  logic [DRAW_HEIGHT_ADDRW-1:0]  clr_y_d, clr_y_q;
  logic                          overrun_d, overrun_q;
  logic                          timeout_err_d, timeout_err_q;

  logic                          beat_vld;
  logic                          beat_transparent;
  logic [DRAW_WIDTH_ADDRW-1:0]   beat_x;
  logic [DRAW_HEIGHT_ADDRW-1:0]  beat_y;
  logic [COLOR_DEPTH-1:0]        beat_color;

  // State, source index, counters and sticky flags.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_IDLE;
      src_q         <= '0;
      tmo_cnt_q     <= '0;
      clr_x_q       <= '0;
      clr_y_q       <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      tmo_cnt_q     <= tmo_cnt_d;
      clr_x_q       <= clr_x_d;
      clr_y_q       <= clr_y_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic; a frame_start in any non-idle state (DONE included) is an overrun.
  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    tmo_cnt_d     = tmo_cnt_q;
    clr_x_d       = clr_x_q;
    clr_y_d       = clr_y_q;
    timeout_err_d = timeout_err_q;
    overrun_d     = overrun_q | (frame_start && (state_q != ST_IDLE));

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          src_d   = '0;
          clr_x_d = '0;
          clr_y_d = '0;
          state_d = clear_en ? ST_CLEAR : ST_SELECT;
        end
      end
      ST_CLEAR: begin
        if (clr_x_q == CLR_X_LAST) begin
          clr_x_d = '0;
          if (clr_y_q == CLR_Y_LAST) begin
            clr_y_d = '0;
            src_d   = '0;
            state_d = ST_SELECT;
          end else begin
            clr_y_d = clr_y_q + DRAW_HEIGHT_ADDRW'(1);
          end
        end else begin
          clr_x_d = clr_x_q + DRAW_WIDTH_ADDRW'(1);
        end
      end
      ST_SELECT: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (write_active) begin
          state_d = ST_STREAM;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_NEXT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_STREAM: begin
        if (!write_active) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (src_q == SRC_LAST) begin
          state_d = ST_DONE;
        end else begin
          src_d   = src_q + SOURCE_SEL_ADDRW'(1);
          state_d = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Beat source: the clear raster in CLEAR, the shared bus in STREAM, nothing otherwise
  // (the bus floats whenever the idle ID is selected).
  always_comb begin
    beat_vld         = 1'b0;
    beat_transparent = 1'b0;
    beat_x           = clr_x_q;
    beat_y           = clr_y_q;
    beat_color       = CLEAR_COLOR;
    if (state_q == ST_CLEAR) begin
      beat_vld = 1'b1;
    end else if (state_q == ST_STREAM) begin
      beat_vld         = write_active;
      beat_transparent = write_transparent;
      beat_x           = write_x_addr;
      beat_y           = write_y_addr;
      beat_color       = write_color_data;
    end
  end

  // Status and bus-ownership outputs decoded from the current state.
  always_comb begin
    busy          = (state_q != ST_IDLE);
    frame_done    = (state_q == ST_DONE);
    write_awaited = (state_q == ST_WAIT);
    if ((state_q == ST_SELECT) || (state_q == ST_WAIT) || (state_q == ST_STREAM)) begin
      write_source_sel = src_q;
    end else begin
      write_source_sel = IDLE_SOURCE_ID;
    end
  end

  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

  draw_addr_gen u_addr_gen (
    .clk              (clk),
    .resetN           (resetN),
    .beat_vld         (beat_vld),
    .beat_transparent (beat_transparent),
    .beat_x           (beat_x),
    .beat_y           (beat_y),
    .beat_color       (beat_color),
    .fb_we            (fb_we),
    .fb_addr          (fb_addr),
    .fb_data          (fb_data)
  );

endmodule

// File: tb/tb_frame_draw_arbiter.sv
// Directed bench for frame_draw_arbiter with two sources and a short timeout.
// Latency: n/a.
// Backpressure: n/a.
module tb_frame_draw_arbiter;
  import frame_draw_arbiter_pkg::*;

  localparam int TMO = 32;
  localparam logic [COLOR_DEPTH-1:0] CLR_C = 8'h5A;
  localparam int NPIX = DRAW_WIDTH * DRAW_HEIGHT;

  logic                         clk = 1'b0;
  logic                         resetN = 1'b1;
  logic                         frame_start = 1'b0;
  logic                         clear_en = 1'b0;
  logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel;
  logic                         write_awaited;
  logic                         write_active = 1'b0;
  logic                         write_transparent = 1'b0;
  logic [COLOR_DEPTH-1:0]       write_color_data = '0;
  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr = '0;
  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr = '0;
  logic                         fb_we;
  logic [FB_ADDRW-1:0]          fb_addr;
  logic [COLOR_DEPTH-1:0]       fb_data;
  logic                         busy, frame_done, overrun, timeout_err;

  int checks = 0;
  int failures = 0;

  frame_draw_arbiter #(.SOURCE_COUNT(2), .TIMEOUT_CYCLES(TMO), .CLEAR_COLOR(CLR_C)) dut (
    .clk(clk), .resetN(resetN), .frame_start(frame_start), .clear_en(clear_en),
    .write_source_sel(write_source_sel), .write_awaited(write_awaited),
    .write_active(write_active), .write_transparent(write_transparent),
    .write_color_data(write_color_data), .write_x_addr(write_x_addr), .write_y_addr(write_y_addr),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic bus_idle;
    write_active = 1'b0; write_transparent = 1'b0; write_color_data = '0;
    write_x_addr = '0; write_y_addr = '0;
  endtask

  task automatic drive_beat(input logic [7:0] x, input logic [6:0] y, input logic [7:0] c, input logic t);
    write_active = 1'b1; write_transparent = t; write_color_data = c;
    write_x_addr = x; write_y_addr = y;
  endtask

  task automatic do_reset;
    resetN = 1'b0; frame_start = 1'b0; clear_en = 1'b0; bus_idle();
    tick(); tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic start_frame(input logic clr);
    frame_start = 1'b1; clear_en = clr;
    tick();
    frame_start = 1'b0; clear_en = 1'b0;
  endtask

  task automatic wait_awaited(output bit ok);
    int n = 0;
    while (!write_awaited && n < 100) begin tick(); n++; end
    ok = write_awaited;
  endtask

  task automatic wait_idle(output bit ok, output int done_cnt, output int we_cnt);
    int n = 0;
    done_cnt = 0; we_cnt = 0;
    while (busy && n < 300) begin
      tick(); n++;
      if (frame_done) done_cnt++;
      if (fb_we) we_cnt++;
    end
    ok = !busy;
  endtask

  task automatic test_reset;
    tick(); tick();
    #2 resetN = 1'b0;
    #1;
    checks++; if (fb_we !== 1'b0) begin failures++; $display("FAIL rst_fb_we got %b want 0", fb_we); end
    checks++; if (fb_addr !== '0) begin failures++; $display("FAIL rst_fb_addr got %0d want 0", fb_addr); end
    checks++; if (fb_data !== '0) begin failures++; $display("FAIL rst_fb_data got %0h want 0", fb_data); end
    checks++; if (write_awaited !== 1'b0) begin failures++; $display("FAIL rst_awaited got %b want 0", write_awaited); end
    checks++; if (write_source_sel !== 3'b111) begin failures++; $display("FAIL rst_sel got %0d want 7", write_source_sel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_done got %b want 0", frame_done); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got %b want 0", overrun); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout got %b want 0", timeout_err); end
    tick();
    resetN = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_release_busy got %b want 0", busy); end
  endtask

  task automatic test_clear_timeout;
    int clr_bad = 0, sel_bad = 0, aw0 = 0, aw1 = 0, done_cnt = 0, we_cnt = 0, n = 0;
    int first_bad = -1;
    logic tmo_at_src1 = 1'b0;
    bit seen_src1 = 0;
    do_reset();
    start_frame(1'b1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clr_busy got %b want 1", busy); end
    checks++; if (fb_we !== 1'b0) begin failures++; $display("FAIL clr_first_we got %b want 0", fb_we); end
    for (int i = 0; i < NPIX; i++) begin
      tick();
      if (fb_we !== 1'b1 || fb_addr !== FB_ADDRW'(i) || fb_data !== CLR_C) begin
        clr_bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (i < NPIX - 1 && (write_source_sel !== 3'b111 || write_awaited !== 1'b0)) sel_bad++;
    end
    checks++; if (clr_bad != 0) begin failures++; $display("FAIL clear_writes got %0d bad (first at %0d) want 0 bad", clr_bad, first_bad); end
    checks++; if (sel_bad != 0) begin failures++; $display("FAIL clear_sel got %0d bad cycles want 0", sel_bad); end
    while (busy && n < 300) begin
      tick(); n++;
      if (write_awaited && write_source_sel == 3'd0) aw0++;
      if (write_awaited && write_source_sel == 3'd1) begin
        aw1++;
        if (!seen_src1) begin seen_src1 = 1; tmo_at_src1 = timeout_err; end
      end
      if (frame_done) done_cnt++;
      if (fb_we) we_cnt++;
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_end_idle got busy=%b want 0", busy); end
    checks++; if (aw0 != TMO) begin failures++; $display("FAIL src0_wait_cycles got %0d want %0d", aw0, TMO); end
    checks++; if (aw1 != TMO) begin failures++; $display("FAIL src1_wait_cycles got %0d want %0d", aw1, TMO); end
    checks++; if (tmo_at_src1 !== 1'b1) begin failures++; $display("FAIL timeout_after_src0 got %b want 1", tmo_at_src1); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL clr_frame_done got %0d pulses want 1", done_cnt); end
    checks++; if (we_cnt != 0) begin failures++; $display("FAIL clr_extra_we got %0d want 0", we_cnt); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL clr_timeout_err got %b want 1", timeout_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL clr_overrun got %b want 0", overrun); end
  endtask

  task automatic test_stream;
    bit ok;
    int done_cnt, we_cnt;
    do_reset();
    drive_beat(8'd5, 7'd2, 8'hAA, 1'b0);
    tick(); tick();
    checks++; if (fb_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_bus_ignored got we=%b busy=%b want 0 0", fb_we, busy); end
    bus_idle();
    start_frame(1'b0);
    checks++; if (write_source_sel !== 3'd0 || write_awaited !== 1'b0) begin failures++; $display("FAIL select_state got sel=%0d aw=%b want 0 0", write_source_sel, write_awaited); end
    wait_awaited(ok);
    checks++; if (!ok || write_source_sel !== 3'd0) begin failures++; $display("FAIL stream_awaited got ok=%0d sel=%0d want 1 0", ok, write_source_sel); end
    write_active = 1'b1;
    tick();
    checks++; if (write_awaited !== 1'b0 || fb_we !== 1'b0) begin failures++; $display("FAIL handshake got aw=%b we=%b want 0 0", write_awaited, fb_we); end
    drive_beat(8'd5, 7'd2, 8'h11, 1'b0); tick();
    checks++; if (fb_we !== 1'b1 || fb_addr !== 15'd325 || fb_data !== 8'h11) begin failures++; $display("FAIL beat_5_2 got we=%b addr=%0d data=%0h want 1 325 11", fb_we, fb_addr, fb_data); end
    drive_beat(8'd159, 7'd119, 8'h22, 1'b0); tick();
    checks++; if (fb_we !== 1'b1 || fb_addr !== 15'd19199 || fb_data !== 8'h22) begin failures++; $display("FAIL beat_159_119 got we=%b addr=%0d data=%0h want 1 19199 22", fb_we, fb_addr, fb_data); end
    drive_beat(8'd0, 7'd0, 8'h33, 1'b0); tick();
    checks++; if (fb_we !== 1'b1 || fb_addr !== 15'd0 || fb_data !== 8'h33) begin failures++; $display("FAIL beat_0_0 got we=%b addr=%0d data=%0h want 1 0 33", fb_we, fb_addr, fb_data); end
    bus_idle(); tick();
    checks++; if (fb_we !== 1'b0 || write_source_sel !== 3'b111) begin failures++; $display("FAIL stream_end got we=%b sel=%0d want 0 7", fb_we, write_source_sel); end
    wait_idle(ok, done_cnt, we_cnt);
    checks++; if (!ok || done_cnt != 1 || we_cnt != 0) begin failures++; $display("FAIL stream_frame got ok=%0d done=%0d we=%0d want 1 1 0", ok, done_cnt, we_cnt); end
  endtask

  task automatic test_drop;
    bit ok;
    int done_cnt, we_cnt;
    do_reset();
    start_frame(1'b0);
    wait_awaited(ok);
    write_active = 1'b1; tick();
    drive_beat(8'd10, 7'd10, 8'h44, 1'b1); tick();
    checks++; if (fb_we !== 1'b0) begin failures++; $display("FAIL drop_transparent got we=%b want 0", fb_we); end
    drive_beat(8'd170, 7'd3, 8'h55, 1'b0); tick();
    checks++; if (fb_we !== 1'b0) begin failures++; $display("FAIL drop_x170 got we=%b want 0", fb_we); end
    drive_beat(8'd0, 7'd120, 8'h56, 1'b0); tick();
    checks++; if (fb_we !== 1'b0) begin failures++; $display("FAIL drop_y120 got we=%b want 0", fb_we); end
    drive_beat(8'd1, 7'd1, 8'h66, 1'b0); tick();
    checks++; if (fb_we !== 1'b1 || fb_addr !== 15'd161 || fb_data !== 8'h66) begin failures++; $display("FAIL after_drop got we=%b addr=%0d data=%0h want 1 161 66", fb_we, fb_addr, fb_data); end
    bus_idle();
    wait_idle(ok, done_cnt, we_cnt);
    checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL drop_frame got ok=%0d done=%0d want 1 1", ok, done_cnt); end
  endtask

  task automatic test_overrun;
    bit ok;
    int done_cnt, we_cnt, n;
    int busy_after = 0;
    do_reset();
    start_frame(1'b0);
    wait_awaited(ok);
    write_active = 1'b1; tick();
    drive_beat(8'd2, 7'd0, 8'h77, 1'b0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_stream got %b want 1", overrun); end
    checks++; if (fb_we !== 1'b1 || fb_addr !== 15'd2) begin failures++; $display("FAIL overrun_beat got we=%b addr=%0d want 1 2", fb_we, fb_addr); end
    drive_beat(8'd3, 7'd0, 8'h78, 1'b0); tick();
    checks++; if (fb_we !== 1'b1 || fb_addr !== 15'd3) begin failures++; $display("FAIL overrun_continue got we=%b addr=%0d want 1 3", fb_we, fb_addr); end
    bus_idle();
    wait_idle(ok, done_cnt, we_cnt);
    checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL overrun_frame got ok=%0d done=%0d want 1 1", ok, done_cnt); end
    for (int i = 0; i < 5; i++) begin tick(); if (busy) busy_after++; end
    checks++; if (busy_after != 0 || overrun !== 1'b1) begin failures++; $display("FAIL overrun_not_queued got busy_cycles=%0d ovr=%b want 0 1", busy_after, overrun); end
    do_reset();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_reset_clear got %b want 0", overrun); end
    start_frame(1'b0);
    n = 0;
    while (!frame_done && n < 300) begin tick(); n++; end
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL done_reach got %b want 1", frame_done); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (overrun !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL overrun_done got ovr=%b busy=%b done=%b want 1 0 0", overrun, busy, frame_done); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int done_cnt = 0, we_cnt = 0;
    do_reset();
    start_frame(1'b0);
    wait_awaited(ok);
    write_active = 1'b1; tick();
    drive_beat(8'd5, 7'd2, 8'h12, 1'b0); tick();
    checks++; if (fb_we !== 1'b1) begin failures++; $display("FAIL mid_pre_we got %b want 1", fb_we); end
    drive_beat(8'd6, 7'd2, 8'h13, 1'b0);
    #2 resetN = 1'b0;
    #1;
    checks++; if (fb_we !== 1'b0 || busy !== 1'b0 || write_source_sel !== 3'b111 || write_awaited !== 1'b0) begin
      failures++; $display("FAIL mid_async got we=%b busy=%b sel=%0d aw=%b want 0 0 7 0", fb_we, busy, write_source_sel, write_awaited);
    end
    tick();
    checks++; if (fb_we !== 1'b0) begin failures++; $display("FAIL mid_hold_we got %b want 0", fb_we); end
    resetN = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame_done) done_cnt++;
      if (fb_we || busy) we_cnt++;
    end
    bus_idle();
    checks++; if (done_cnt != 0 || we_cnt != 0) begin failures++; $display("FAIL mid_abandon got done=%0d we_or_busy=%0d want 0 0", done_cnt, we_cnt); end
  endtask

  task automatic test_late_source;
    bit ok;
    int aw = 0;
    do_reset();
    start_frame(1'b0);
    wait_awaited(ok);
    write_active = 1'b1; tick();
    bus_idle(); tick();
    wait_awaited(ok);
    checks++; if (!ok || write_source_sel !== 3'd1) begin failures++; $display("FAIL late_src1_sel got ok=%0d sel=%0d want 1 1", ok, write_source_sel); end
    for (int i = 0; i < 9; i++) begin tick(); if (write_awaited) aw++; end
    checks++; if (aw != 9) begin failures++; $display("FAIL late_wait got %0d awaited cycles want 9", aw); end
    write_active = 1'b1; tick();
    checks++; if (write_awaited !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL late_stream got aw=%b tmo=%b want 0 0", write_awaited, timeout_err); end
    drive_beat(8'd3, 7'd0, 8'h88, 1'b0); tick();
    checks++; if (fb_we !== 1'b1 || fb_addr !== 15'd3 || fb_data !== 8'h88) begin failures++; $display("FAIL late_beat0 got we=%b addr=%0d data=%0h want 1 3 88", fb_we, fb_addr, fb_data); end
    drive_beat(8'd0, 7'd1, 8'h99, 1'b0); tick();
    checks++; if (fb_we !== 1'b1 || fb_addr !== 15'd160 || fb_data !== 8'h99) begin failures++; $display("FAIL late_beat1 got we=%b addr=%0d data=%0h want 1 160 99", fb_we, fb_addr, fb_data); end
    bus_idle(); tick();
    checks++; if (frame_done !== 1'b0 || fb_we !== 1'b0) begin failures++; $display("FAIL late_next got done=%b we=%b want 0 0", frame_done, fb_we); end
    tick();
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL late_done got %b want 1", frame_done); end
    tick();
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL late_idle got done=%b busy=%b tmo=%b want 0 0 0", frame_done, busy, timeout_err); end
  endtask

  initial begin
    test_reset();
    test_clear_timeout();
    test_stream();
    test_drop();
    test_overrun();
    test_reset_mid();
    test_late_source();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
